// File: rtl/rou_pkg.sv
// Shared roubus definitions for the message output arbiter and its picker.
// Holds cmd encodings, field positions and the message width derivation.
package rou_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam int CMD_LSB = 0;
  localparam int CMD_W   = 2;

  function automatic int roubus_wid(
    input int dwid,
    input int awid,
    input int bwid,
    input int twid
  );
    return CMD_W + dwid + awid + bwid + twid;
  endfunction

  localparam int ROU_WID = roubus_wid(128, 32, 5, 4);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_t;

endpackage

// File: rtl/rou_rr_pick.sv
// Combinational rotating-priority picker: search starts just after last.
// Returns a one-hot grant plus its index; reusable for depot allocation.
module rou_rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] elig,
  input  logic [1:0]   last,
  output logic [N-1:0] grant,
  output logic [1:0]   idx,
  output logic         any
);

  always_comb begin
    int p;
    p     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      p = (int'(last) + k) % N;
      if (!any && elig[p]) begin
        any      = 1'b1;
        grant[p] = 1'b1;
        idx      = 2'(p);
      end
    end
  end

endmodule

// File: rtl/rou_out_arb.sv
// Round-robin arbiter for the shared roubus message output with a
// one-entry registered stage and outstanding-read credit gating.
module rou_out_arb
  import rou_pkg::*;
#(
  parameter int WID    = ROU_WID,
  parameter int NREQ   = 3,
  parameter int MAX_RD = 8,
  parameter int CWID   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*WID-1:0] req_msg,
  output logic [NREQ-1:0]     req_ack,
  output logic [WID-1:0]      msg_out,
  input  logic                msg_out_ack,
  input  logic                rd_done,
  output logic [CWID-1:0]     rd_outstanding,
  output logic [1:0]          grant_idx,
  output logic                rd_underflow
);

  stage_t          state_q, state_d;
  logic [WID-1:0]  msg_q, msg_d;
  logic [1:0]      last_q;
  logic [1:0]      gidx_q;
  logic [CWID-1:0] cnt_q;
  logic            uf_q;

  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic [1:0]      win_idx;
  logic            any_elig;
  logic [WID-1:0]  win_msg;

  logic            held_read;
  logic [CWID:0]   committed;
  logic            credit_ok;
  logic            take;
  logic            load;
  logic            inc;
  logic            dec;

  // A held read counts against credit until its ack lands in the counter.
  assign held_read = (state_q == ST_FULL) &&
                     (msg_q[CMD_LSB +: CMD_W] == CMD_READ);
  assign committed = {1'b0, cnt_q} + {{CWID{1'b0}}, held_read};
  assign credit_ok = committed < (CWID+1)'(MAX_RD);

  always_comb begin
    logic [1:0] c;
    c    = CMD_IDLE;
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      c = req_msg[i*WID+CMD_LSB +: CMD_W];
      elig[i] = req_valid[i] && (c != CMD_IDLE) &&
                ((c != CMD_READ) || credit_ok);
    end
  end

  rou_rr_pick #(
    .N (NREQ)
  ) u_pick (
    .elig  (elig),
    .last  (last_q),
    .grant (grant),
    .idx   (win_idx),
    .any   (any_elig)
  );

  assign win_msg = req_msg[int'(win_idx)*WID +: WID];

  assign take    = (state_q == ST_EMPTY) || msg_out_ack;
  assign load    = take && any_elig;
  assign req_ack = load ? grant : '0;

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (load) begin
          state_d = ST_FULL;
          msg_d   = win_msg;
        end
      end
      ST_FULL: begin
        if (msg_out_ack) begin
          if (load) begin
            msg_d = win_msg;
          end else begin
            state_d = ST_EMPTY;
            msg_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        msg_d   = '0;
      end
    endcase
  end

  assign inc = msg_out_ack && held_read;
  assign dec = rd_done && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      msg_q   <= '0;
      last_q  <= 2'(NREQ-1);
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      if (load) begin
        last_q <= win_idx;
        gidx_q <= win_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      if (inc && !dec) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (dec && !inc) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (rd_done && (cnt_q == '0)) begin
        uf_q <= 1'b1;
      end
    end
  end

  assign msg_out        = msg_q;
  assign grant_idx      = gidx_q;
  assign rd_outstanding = cnt_q;
  assign rd_underflow   = uf_q;

endmodule

// File: tb/tb_rou_out_arb.sv
// Self-checking bench for rou_out_arb: vector table, credit/reset
// sequences and randomized traffic against a behavioural model.
module tb_rou_out_arb;

  localparam int WID    = 16;
  localparam int NREQ   = 3;
  localparam int MAX_RD = 2;
  localparam int CWID   = 4;

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic                clk;
  logic                clk_run;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*WID-1:0] req_msg;
  logic [NREQ-1:0]     req_ack;
  logic [WID-1:0]      msg_out;
  logic                msg_out_ack;
  logic                rd_done;
  logic [CWID-1:0]     rd_outstanding;
  logic [1:0]          grant_idx;
  logic                rd_underflow;

  logic [WID-1:0] m [NREQ];

  int checks;
  int passes;

  // behavioural model state
  bit             mh;
  logic [WID-1:0] mmsg;
  int             midx;
  int             mlast;
  int             mcnt;
  bit             muf;
  int             mwin;

  assign req_msg = {m[2], m[1], m[0]};

  rou_out_arb #(
    .WID    (WID),
    .NREQ   (NREQ),
    .MAX_RD (MAX_RD),
    .CWID   (CWID)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_msg        (req_msg),
    .req_ack        (req_ack),
    .msg_out        (msg_out),
    .msg_out_ack    (msg_out_ack),
    .rd_done        (rd_done),
    .rd_outstanding (rd_outstanding),
    .grant_idx      (grant_idx),
    .rd_underflow   (rd_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = clk_run ? ~clk : clk;

  typedef struct packed {
    logic [2:0]     v;
    logic [1:0]     c0;
    logic [1:0]     c1;
    logic [1:0]     c2;
    logic           ack;
    logic [2:0]     e_ack;
    logic [WID-1:0] e_msg;
    logic [1:0]     e_gidx;
  } vec_t;

  function automatic logic [WID-1:0] mk(input int i, input logic [1:0] c);
    return {4'(i+1), 10'h0, c};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    req_valid   = '0;
    msg_out_ack = 1'b0;
    rd_done     = 1'b0;
    for (int i = 0; i < NREQ; i++) m[i] = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_msg", 32'(msg_out), 0);
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_cnt", 32'(rd_outstanding), 0);
    chk("rst_gidx", 32'(grant_idx), 0);
    chk("rst_uf", 32'(rd_underflow), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mh = 0; mmsg = '0; midx = 0; mlast = NREQ-1;
    mcnt = 0; muf = 0; mwin = -1;
  endtask

  // Applies the arbitration rules to the current inputs, checks the
  // DUT, then advances the model by one clock.
  task automatic model_cycle();
    int w;
    int hr;
    int p;
    bit can;
    logic [2:0] ea;
    hr  = (mh && mmsg[1:0] == R) ? 1 : 0;
    can = !mh || msg_out_ack;
    w   = -1;
    if (can) begin
      for (int k = 1; k <= NREQ; k++) begin
        p = (mlast + k) % NREQ;
        if (w < 0 && req_valid[p] && m[p][1:0] != I &&
            (m[p][1:0] != R || mcnt + hr < MAX_RD))
          w = p;
      end
    end
    ea = (w >= 0) ? 3'(1 << w) : 3'b000;
    chk("rnd_ack", 32'(req_ack), 32'(ea));
    chk("rnd_msg", 32'(msg_out), mh ? 32'(mmsg) : 0);
    chk("rnd_gidx", 32'(grant_idx), 32'(midx));
    chk("rnd_cnt", 32'(rd_outstanding), 32'(mcnt));
    chk("rnd_uf", 32'(rd_underflow), 32'(muf));
    chk("rnd_cap", 32'(rd_outstanding <= CWID'(MAX_RD)), 1);
    if (rd_done && mcnt == 0) muf = 1;
    mcnt = mcnt + ((msg_out_ack && hr == 1) ? 1 : 0)
                - ((rd_done && mcnt > 0) ? 1 : 0);
    if (w >= 0) begin
      mh = 1; mmsg = m[w]; midx = w; mlast = w;
    end else if (mh && msg_out_ack) begin
      mh = 0;
    end
    mwin = w;
  endtask

  vec_t tbl [21];
  int   n0, n1, r;

  initial begin
    checks  = 0;
    passes  = 0;
    clk_run = 1'b1;
    rst_n   = 1'b0;

    tbl[0]  = '{3'b001, W, I, I, 1'b1, 3'b001, 16'h0, 2'd0};
    tbl[1]  = '{3'b000, W, I, I, 1'b1, 3'b000, mk(0, W), 2'd0};
    tbl[2]  = '{3'b000, W, I, I, 1'b1, 3'b000, 16'h0, 2'd0};
    tbl[3]  = '{3'b111, W, W, W, 1'b1, 3'b010, 16'h0, 2'd0};
    tbl[4]  = '{3'b111, W, W, W, 1'b1, 3'b100, mk(1, W), 2'd1};
    tbl[5]  = '{3'b111, W, W, W, 1'b1, 3'b001, mk(2, W), 2'd2};
    tbl[6]  = '{3'b111, W, W, W, 1'b1, 3'b010, mk(0, W), 2'd0};
    tbl[7]  = '{3'b111, W, W, W, 1'b1, 3'b100, mk(1, W), 2'd1};
    tbl[8]  = '{3'b000, W, W, W, 1'b1, 3'b000, mk(2, W), 2'd2};
    tbl[9]  = '{3'b000, W, W, W, 1'b1, 3'b000, 16'h0, 2'd2};
    tbl[10] = '{3'b001, W, W, W, 1'b0, 3'b001, 16'h0, 2'd2};
    tbl[11] = '{3'b010, W, W, W, 1'b0, 3'b000, mk(0, W), 2'd0};
    tbl[12] = '{3'b010, W, W, W, 1'b0, 3'b000, mk(0, W), 2'd0};
    tbl[13] = '{3'b010, W, W, W, 1'b0, 3'b000, mk(0, W), 2'd0};
    tbl[14] = '{3'b010, W, W, W, 1'b0, 3'b000, mk(0, W), 2'd0};
    tbl[15] = '{3'b010, W, W, W, 1'b0, 3'b000, mk(0, W), 2'd0};
    tbl[16] = '{3'b010, W, W, W, 1'b1, 3'b010, mk(0, W), 2'd0};
    tbl[17] = '{3'b000, W, W, W, 1'b1, 3'b000, mk(1, W), 2'd1};
    tbl[18] = '{3'b000, W, W, W, 1'b0, 3'b000, 16'h0, 2'd1};
    tbl[19] = '{3'b001, I, W, W, 1'b0, 3'b000, 16'h0, 2'd1};
    tbl[20] = '{3'b001, I, W, W, 1'b1, 3'b000, 16'h0, 2'd1};

    do_reset();
    for (int k = 0; k < 21; k++) begin
      req_valid   = tbl[k].v;
      m[0]        = mk(0, tbl[k].c0);
      m[1]        = mk(1, tbl[k].c1);
      m[2]        = mk(2, tbl[k].c2);
      msg_out_ack = tbl[k].ack;
      @(negedge clk);
      chk($sformatf("tbl%0d_ack", k), 32'(req_ack), 32'(tbl[k].e_ack));
      chk($sformatf("tbl%0d_msg", k), 32'(msg_out), 32'(tbl[k].e_msg));
      chk($sformatf("tbl%0d_gidx", k), 32'(grant_idx), 32'(tbl[k].e_gidx));
      @(posedge clk);
      #1;
    end
    chk("tbl_cnt", 32'(rd_outstanding), 0);

    // Credit exhaustion: req0 reads, req1 writes, reads never complete.
    do_reset();
    req_valid   = 3'b011;
    m[0]        = mk(0, R);
    m[1]        = mk(1, W);
    msg_out_ack = 1'b1;
    n0 = 0;
    n1 = 0;
    repeat (8) begin
      @(negedge clk);
      n0 += int'(req_ack[0]);
      n1 += int'(req_ack[1]);
      @(posedge clk);
      #1;
    end
    chk("cr_reads", 32'(n0), 2);
    chk("cr_writes", 32'(n1), 6);
    chk("cr_cnt2", 32'(rd_outstanding), 2);
    rd_done = 1'b1;
    @(negedge clk);
    chk("cr_blocked", 32'(req_ack), 3'b010);
    @(posedge clk);
    #1;
    rd_done = 1'b0;
    chk("cr_cnt1", 32'(rd_outstanding), 1);
    @(negedge clk);
    chk("cr_third", 32'(req_ack), 3'b001);
    @(posedge clk);
    #1;
    rd_done = 1'b1;
    @(negedge clk);
    chk("cr_full_wr", 32'(req_ack), 3'b010);
    @(posedge clk);
    #1;
    rd_done = 1'b0;
    chk("cr_incdec", 32'(rd_outstanding), 1);

    // Underflow, then an async reset with the clock stopped.
    do_reset();
    rd_done = 1'b1;
    @(posedge clk);
    #1;
    rd_done = 1'b0;
    chk("uf_flag", 32'(rd_underflow), 1);
    chk("uf_cnt", 32'(rd_outstanding), 0);
    req_valid   = 3'b001;
    m[0]        = mk(0, R);
    msg_out_ack = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 3'b010;
    m[1]      = mk(1, W);
    @(posedge clk);
    #1;
    req_valid   = 3'b000;
    msg_out_ack = 1'b0;
    @(negedge clk);
    chk("ar_held", 32'(msg_out), 32'(mk(1, W)));
    chk("ar_cnt_pre", 32'(rd_outstanding), 1);
    clk_run = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_msg", 32'(msg_out), 0);
    chk("ar_cnt", 32'(rd_outstanding), 0);
    chk("ar_uf", 32'(rd_underflow), 0);
    chk("ar_gidx", 32'(grant_idx), 0);
    #3;
    rst_n = 1'b1;
    #2;
    clk_run = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_idle", 32'(msg_out), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (mwin == i) req_valid[i] = 1'b0;
        if (!req_valid[i] && ($urandom % 3) == 0) begin
          r = int'($urandom % 8);
          m[i] = WID'($urandom);
          m[i][1:0] = (r == 0) ? I : (r < 4) ? R : (r < 7) ? W : 2'b11;
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && m[i][1:0] == I &&
                     ($urandom % 4) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      msg_out_ack = ($urandom % 4) != 0;
      rd_done     = (mcnt > 0) && (($urandom % 3) == 0);
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rou_out_arb.md
Name: rou_out_arb

Overview:
- Round-robin scheduler sharing the single roubus message output (msg_out/msg_out_ack of rou_nif) between up to 4 message sources, e.g. the read-request FIFO, the write path and a future DMA engine.
- Each arbitration decision is registered in a one-entry output stage.
- Read requests (cmd==2'b01) are throttled by an outstanding-read credit counter, so the read data FIFO and depots can never be oversubscribed.

Parameters:
- WID, 171, roubus message width (2+DWID+AWID+BWID+TWID for DWID=128, AWID=32); cmd is msg[1:0].
- NREQ, 3, number of requesters, 2..4.
- MAX_RD, 8, maximum reads in flight, 1..15.
- CWID, 4, width of the outstanding-read counter; must hold MAX_RD.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester message valid.
- req_msg  input  NREQ*WID  requester i occupies bits [i*WID +: WID].
- req_ack  output  NREQ  one-hot pulse: the message was taken into the output stage.
- msg_out  output  WID  to rou_nif msg_out; cmd==0 means idle.
- msg_out_ack  input  1  rou_nif accepted msg_out this cycle.
- rd_done  input  1  one pulse per completed read (rlast && rvalid && rready).
- rd_outstanding  output  CWID  current reads in flight.
- grant_idx  output  2  index of the requester currently held in the output stage.
- rd_underflow  output  1  sticky error flag: rd_done arrived while the counter was 0.

Behaviour:
- Reset (async, rst_n=0): output stage EMPTY, msg_out=0, req_ack=0, rd_outstanding=0, grant_idx=0, rd_underflow=0, round-robin pointer last=NREQ-1 (so requester 0 has first priority).
- Output stage FSM, two states:
  - EMPTY: msg_out=0. If any requester is eligible, load the winner's message, pulse req_ack[winner], go to FULL.
  - FULL: msg_out holds the stored message and stays stable until msg_out_ack.
  - On msg_out_ack with an eligible requester: reload in the same cycle (back-to-back, one message per cycle) and stay FULL.
  - On msg_out_ack with no eligible requester: go to EMPTY.
  - msg_out_ack while EMPTY is ignored.
- Latency: req_valid asserted in cycle N with an idle stage -> msg_out valid in N+1. req_ack is combinational with the load decision, asserted in cycle N.
- Eligibility: req_valid[i] && (req_msg_i cmd != 2'b00) && (cmd != 2'b01 || credit_ok).
  - Valid messages with cmd==0 are never granted and never acked.
- credit_ok definition: (rd_outstanding + held_read) < MAX_RD, where held_read=1 if the stage is FULL with a read that has not yet been acked.
  - Consequence: once MAX_RD reads are committed, a further read cannot be loaded, including in a reload cycle.
- Arbitration: search indices last+1, last+2, ... modulo NREQ; the first eligible index wins. last updates to the winner on every load.
  - An ineligible read is skipped without losing its turn order; later requesters are granted instead.
- Requester contract: req_msg must stay stable from req_valid until req_ack. The arbiter never acks a requester whose req_valid is low.
- Read counter (updated on clk):
  - inc = msg_out_ack && FULL && msg_out cmd==2'b01.
  - dec = rd_done && rd_outstanding!=0.
  - inc and dec in the same cycle -> unchanged.
  - rd_done with the counter at 0 -> no change; rd_underflow set to 1, cleared only by reset.
  - The counter never exceeds MAX_RD; the credit rule guarantees this. The verification engineer asserts it.
- Writes (cmd 2'b10) and any other nonzero cmd are never credit-gated.
- Reset mid-operation: a held message is dropped and the counter is cleared. System integration must reset the depots and the rd_data FIFO together.

Decomposition:
- Shared package rou_pkg holds:
  - roubus cmd constants: CMD_IDLE=2'b00, CMD_READ=2'b01, CMD_WRITE=2'b10.
  - WID derivation function.
  - cmd field slice positions.
- One sub-module, rou_rr_pick: a combinational NREQ-way rotating priority picker. Inputs: eligible vector and last pointer. Outputs: one-hot grant and index. It is reusable for depot allocation.

Test Plan:
- Reset, then req0 write valid; msg_out_ack tied 1 -> req_ack[0] in cycle 0, msg_out=req0 msg in cycle 1, stage EMPTY in cycle 2.
- All three requesters issue continuous writes, ack always 1 -> grant order 0,1,2,0,1,2; one message per cycle; no gaps.
- MAX_RD=2, req0 issues 4 reads, rd_done withheld -> exactly 2 reads acked, rd_outstanding=2. Req1 writes still flow. One rd_done pulse -> third read loads next cycle.
- Counter at 1; ack of a read and rd_done in the same cycle -> rd_outstanding stays 1.
- msg_out_ack held 0 for 5 cycles while FULL -> msg_out stable, no req_ack. Ack in cycle 6 -> next winner loaded in the same cycle.
- rd_done with counter 0 -> rd_underflow=1 and counter 0. Async rst_n pulse mid-stream, clock stopped -> msg_out=0, counter 0, flag cleared immediately.
